// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, bubble encoding,
// fetch state machine encoding and the IF/ID register layout.
package instruction_fetch_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0,x0,0 -- decodes as a harmless I-ALU op downstream
    localparam logic [31:0] NOP_INSTR_C = {25'd0, OPC_I_ALU};

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FETCH = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction memory port, IF/ID outputs.
interface instruction_fetch_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic        if_valid;

    // master: pipeline control plus instruction memory; slave: the fetch unit
    modport master (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, if_pc, if_instr, opcode, if_valid
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, if_pc, if_instr, opcode, if_valid
    );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter: reset > load target > hold > advance by 4, always word aligned.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (load_i) begin
            pc_d = target_i & PC_ALIGN_MASK;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC & PC_ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, IF/ID pipeline register and fetch state machine.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.slave   bus
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         pc_load;
    logic         pc_hold;
    ifid_op_e     ifid_op;
    logic [31:0]  pc;
    ifid_t        ifid_q;
    ifid_t        ifid_d;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (pc_hold),
        .load_i   (pc_load),
        .target_i (bus.branch_target),
        .pc_o     (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FIRST;
            ST_FIRST: if (!bus.stall && !bus.branch_taken) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A taken branch overrides a stall so the wrong-path fetch is always flushed
    always_comb begin
        pc_load = 1'b0;
        pc_hold = 1'b0;
        ifid_op = IFID_FETCH;
        if (bus.branch_taken) begin
            pc_load = 1'b1;
            ifid_op = IFID_FLUSH;
        end else if (bus.stall) begin
            pc_hold = 1'b1;
            ifid_op = IFID_HOLD;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        unique case (ifid_op)
            IFID_FETCH: ifid_d = '{pc: pc, instr: bus.imem_rdata, valid: 1'b1};
            IFID_FLUSH: ifid_d = '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
            default:    ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.if_pc     = ifid_q.pc;
    assign bus.if_instr  = ifid_q.instr;
    assign bus.opcode    = ifid_q.instr[6:0];
    assign bus.if_valid  = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations plus
// randomized control traffic compared every cycle against a behavioural model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: addi x1,x0,a at a = 0,4,8; a scrambled word elsewhere
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        logic [31:0] h;
        if (a < 32'd12) return 32'h0000_0093 | (a << 20);
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return {h[31:7], (h[0] ? 7'b0110011 : 7'b0000011)};
    endfunction

    assign bus.imem_rdata = instr_at(bus.imem_addr);

    // Behavioural model of the fetch stage
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid;
    bit          m_known;

    initial m_known = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc    = RST_PC;
            m_ifpc  = RST_PC;
            m_instr = NOP;
            m_valid = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (bus.branch_taken) begin
                m_ifpc  = m_pc;
                m_instr = NOP;
                m_valid = 1'b0;
                m_pc    = bus.branch_target & 32'hFFFF_FFFC;
            end else if (!bus.stall) begin
                m_ifpc  = m_pc;
                m_instr = instr_at(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            cmp("model_imem_addr", bus.imem_addr, m_pc);
            cmp("model_if_pc", bus.if_pc, m_ifpc);
            cmp("model_if_instr", bus.if_instr, m_instr);
            cmp("model_opcode", {25'd0, bus.opcode}, {25'd0, m_instr[6:0]});
            cmp("model_if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        step();
        step();
        cmp("rst_imem_addr", bus.imem_addr, 32'h0);
        cmp("rst_if_valid", {31'd0, bus.if_valid}, 32'h0);
        cmp("rst_if_instr", bus.if_instr, 32'h13);
        cmp("rst_opcode", {25'd0, bus.opcode}, 32'h13);

        // Release: fetch 0,4,8
        reset = 1'b0;
        step();
        cmp("rel_imem_addr4", bus.imem_addr, 32'h4);
        cmp("rel_if_pc0", bus.if_pc, 32'h0);
        cmp("rel_if_valid", {31'd0, bus.if_valid}, 32'h1);
        cmp("rel_if_instr0", bus.if_instr, 32'h0000_0093);
        step();
        cmp("rel_imem_addr8", bus.imem_addr, 32'h8);
        cmp("rel_if_instr4", bus.if_instr, 32'h0040_0093);

        // Three-cycle stall at PC=8
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("stall_imem_addr", bus.imem_addr, 32'h8);
            cmp("stall_if_pc", bus.if_pc, 32'h4);
            cmp("stall_if_instr", bus.if_instr, 32'h0040_0093);
        end
        bus.stall = 1'b0;
        step();
        cmp("unstall_imem_addr", bus.imem_addr, 32'hC);
        cmp("unstall_if_instr", bus.if_instr, 32'h0080_0093);
        step();
        cmp("pc16", bus.imem_addr, 32'h10);

        // Branch to 0x40 from PC=16
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h40;
        step();
        cmp("br_imem_addr", bus.imem_addr, 32'h40);
        cmp("br_if_instr", bus.if_instr, 32'h13);
        cmp("br_if_valid", {31'd0, bus.if_valid}, 32'h0);
        bus.branch_taken = 1'b0;
        step();
        cmp("br_if_pc", bus.if_pc, 32'h40);
        cmp("br_next_valid", {31'd0, bus.if_valid}, 32'h1);

        // Branch and stall together, misaligned target
        bus.branch_taken = 1'b1;
        bus.stall = 1'b1;
        bus.branch_target = 32'h22;
        step();
        cmp("brstall_imem_addr", bus.imem_addr, 32'h20);
        bus.stall = 1'b0;

        // Wrap at the top of the address space
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        cmp("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        bus.branch_taken = 1'b0;
        step();
        cmp("wrap_zero", bus.imem_addr, 32'h0);
        cmp("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);

        // Back-to-back branches
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h100;
        step();
        bus.branch_target = 32'h207;
        step();
        cmp("b2b_imem_addr", bus.imem_addr, 32'h204);
        cmp("b2b_if_pc", bus.if_pc, 32'h100);
        cmp("b2b_if_valid", {31'd0, bus.if_valid}, 32'h0);
        bus.branch_taken = 1'b0;

        // Reset during a stall
        bus.stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        cmp("rststall_pc", bus.imem_addr, RST_PC);
        cmp("rststall_valid", {31'd0, bus.if_valid}, 32'h0);
        cmp("rststall_opcode", {25'd0, bus.opcode}, 32'h13);
        reset = 1'b0;
        bus.stall = 1'b0;
        step();
        cmp("rststall_first", bus.if_pc, RST_PC);
        cmp("rststall_first_valid", {31'd0, bus.if_valid}, 32'h1);

        // Randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom();
            reset = (r[5:0] == 6'd0);
            bus.stall = (r[9:8] == 2'd0);
            bus.branch_taken = (r[14:12] < 3'd2);
            if (r[16]) bus.branch_target = 32'hFFFF_FFF0 | {28'd0, r[23:20]};
            else bus.branch_target = $urandom();
            step();
        end
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble written into the IF/ID register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID contents this cycle.
REQ-006 branch_taken  input  1  redirect request; already qualified upstream as branch AND ALU zero.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_addr  output  32  word address to instruction memory; equals current PC, combinational from the PC register.
REQ-009 imem_rdata  input  32  instruction word; combinational read of imem_addr, same cycle.
REQ-010 if_pc  output  32  PC of the instruction held in IF/ID.
REQ-011 if_instr  output  32  instruction held in IF/ID.
REQ-012 opcode  output  7  if_instr[6:0]; feeds the control unit directly.
REQ-013 if_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).

Function
REQ-014 PC register: 32 bits; bits [1:0] always 0.
REQ-015 Per-edge priority: reset > branch_taken > stall > normal advance.
REQ-016 Normal advance: PC <= PC + 4; IF/ID <= {PC, imem_rdata}; if_valid <= 1.
REQ-017 Latency: instruction at address A appears on if_instr/opcode exactly one cycle after imem_addr == A.
REQ-018 Stall (no branch): PC, if_pc, if_instr and if_valid are all held unchanged.
REQ-019 Branch: PC <= {branch_target[31:2],2'b00}; IF/ID <= {PC, NOP_INSTR}; if_valid <= 0. This flushes the wrong-path fetch.
REQ-020 Branch with stall in the same cycle: the branch wins; stall is ignored for that edge.
REQ-021 Misaligned branch_target: bits [1:0] are silently cleared; no error output exists.
REQ-022 PC + 4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 Fetch state machine: IDLE (reset held), FIRST (first cycle after reset release, IF/ID still a bubble), RUN.
REQ-024 State transitions: IDLE -> FIRST when reset deasserts; FIRST -> RUN on the next edge unless stall or branch is asserted; RUN -> IDLE only on reset.
REQ-025 In FIRST, stall and branch follow REQ-018 and REQ-019; the state stays FIRST until a normal advance occurs.
REQ-026 Consecutive branches on back-to-back cycles each redirect PC; if_valid stays 0 throughout.

Reset
REQ-027 While reset is high at an edge: PC <= RESET_PC, if_pc <= RESET_PC, if_instr <= NOP_INSTR, if_valid <= 0, state <= IDLE.
REQ-028 Reset mid-stall or mid-branch discards the pending operation; the first fetch after release is RESET_PC.
REQ-029 opcode reads 7'b0010011 during and immediately after reset, so the downstream control unit decodes a harmless addi.

Structure
REQ-030 A shared package holds: opcode constants (R-type 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011), the NOP_INSTR constant, and the fetch state enum.
REQ-031 One sub-module, pc_register, holds the PC with reset, hold and load-target controls; IF/ID and the FSM stay in instruction_fetch.

Verification
REQ-032 Reset then release with RESET_PC=0 and memory holding addi at addresses 0,4,8 -> imem_addr 0,4,8; if_valid rises one cycle after release with if_pc=0.
REQ-033 Stall asserted 3 cycles at PC=8 -> imem_addr stays 8 and if_pc/if_instr are frozen; advance resumes at 12 on release.
REQ-034 branch_taken with target 32'h40 at PC=16 -> next imem_addr=32'h40, if_instr=32'h13, if_valid=0; then if_pc=32'h40 one cycle later.
REQ-035 branch_taken and stall together, target 32'h22 -> PC=32'h20 (branch wins, low bits cleared).
REQ-036 PC forced to 32'hFFFF_FFFC by branch, then one free advance -> imem_addr=0; reset asserted during a stall -> PC=RESET_PC and if_valid=0.
